// File: rtl/cpu_clk_step.sv
// CPU clock source: follows a divider bit in run mode, or issues one debounced
// fixed-width pulse per button press in single-step mode.
module cpu_clk_step #(
    parameter int DEB_BIT    = 17,
    parameter int DEB_COUNT  = 4,
    parameter int FAST_BIT   = 2,
    parameter int SLOW_BIT   = 24,
    parameter int PULSE_HIGH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic        SW2,
    input  logic        step_mode,
    input  logic        step_btn,
    output logic        Clk_CPU,
    output logic        btn_clean,
    output logic [15:0] step_count,
    output logic        busy
);
    localparam logic [3:0] DEB_LAST   = 4'(DEB_COUNT - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_HIGH - 1);

    typedef enum logic [1:0] {RUN, IDLE, PULSE, WAIT_REL} state_t;

    state_t      state, state_next;
    logic        sync_p0, sync_p1;
    logic        deb_prev, clean_prev;
    logic [3:0]  deb_cnt;
    logic [7:0]  pulse_cnt, pulse_next;
    logic        clk_next, busy_next;
    logic [15:0] count_next;
    logic        run_bit, tick, press;
    logic        div_unused;

    // Only a few divider bits are consumed; fold the rest so they count as read.
    assign div_unused = ^clkdiv;

    assign run_bit = SW2 ? clkdiv[SLOW_BIT] : clkdiv[FAST_BIT];
    assign tick    = clkdiv[DEB_BIT] & ~deb_prev;
    assign press   = btn_clean & ~clean_prev;

    // Button synchronizer (sync_p0 -> sync_p1) and tick-sampled debouncer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            deb_prev   <= 1'b0;
            deb_cnt    <= 4'd0;
            btn_clean  <= 1'b0;
            clean_prev <= 1'b0;
        end else begin
            sync_p0    <= step_btn;
            sync_p1    <= sync_p0;
            deb_prev   <= clkdiv[DEB_BIT];
            clean_prev <= btn_clean;
            if (tick) begin
                if (sync_p1 == btn_clean) begin
                    deb_cnt <= 4'd0;
                end else if (deb_cnt == DEB_LAST) begin
                    btn_clean <= ~btn_clean;
                    deb_cnt   <= 4'd0;
                end else begin
                    deb_cnt <= deb_cnt + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            Clk_CPU    <= 1'b0;
            pulse_cnt  <= 8'd0;
            step_count <= 16'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            Clk_CPU    <= clk_next;
            pulse_cnt  <= pulse_next;
            step_count <= count_next;
            busy       <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        clk_next   = Clk_CPU;
        pulse_next = pulse_cnt;
        count_next = step_count;
        case (state)
            RUN: begin
                // Leave only on a low phase so the CPU never sees a runt high.
                clk_next = run_bit;
                if (step_mode && !run_bit) state_next = IDLE;
            end
            IDLE: begin
                clk_next = 1'b0;
                if (!step_mode && !run_bit) begin
                    state_next = RUN;
                end else if (press) begin
                    state_next = PULSE;
                    clk_next   = 1'b1;
                    pulse_next = PULSE_LAST;
                    count_next = step_count + 16'd1;
                end
            end
            PULSE: begin
                clk_next = 1'b1;
                if (pulse_cnt == 8'd0) begin
                    clk_next   = 1'b0;
                    state_next = WAIT_REL;
                end else begin
                    pulse_next = pulse_cnt - 8'd1;
                end
            end
            WAIT_REL: begin
                clk_next = 1'b0;
                if (!btn_clean) state_next = IDLE;
            end
            default: begin
                clk_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next == PULSE) || (state_next == WAIT_REL);
    end
endmodule

// File: tb/tb_cpu_clk_step.sv
// Self-checking bench for cpu_clk_step: run-mode vector table with a one-cycle
// scoreboard, plus hand-written step, bounce, mode-switch and reset sequences.
module tb_cpu_clk_step;
    localparam int DEB_B = 2;
    localparam int PH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] clkdiv = 32'd0;
    logic        SW2 = 1'b0;
    logic        step_mode = 1'b0;
    logic        step_btn = 1'b0;
    logic        Clk_CPU;
    logic        btn_clean;
    logic [15:0] step_count;
    logic        busy;

    cpu_clk_step #(
        .DEB_BIT(DEB_B), .DEB_COUNT(4), .FAST_BIT(2), .SLOW_BIT(24), .PULSE_HIGH(PH)
    ) dut (
        .clk(clk), .rst(rst), .clkdiv(clkdiv), .SW2(SW2), .step_mode(step_mode),
        .step_btn(step_btn), .Clk_CPU(Clk_CPU), .btn_clean(btn_clean),
        .step_count(step_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sw2;
        logic [31:0] div;
        logic        exp_clk;
    } vec_t;

    vec_t        vecs[11];
    logic        exp_q[$];
    logic [15:0] sc_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ticks = 0;
    logic        last_b2 = 1'b0;
    logic        count_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; bench-side tick count mirrors what the debouncer samples.
    task automatic adv();
        @(posedge clk);
        if (rst) begin
            last_b2 = 1'b0;
        end else begin
            if (clkdiv[DEB_B] && !last_b2) ticks++;
            last_b2 = clkdiv[DEB_B];
        end
        #1;
        if (count_en) clkdiv = clkdiv + 32'd1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_clk", Clk_CPU, 0);
        check("rst_clean", btn_clean, 0);
        check("rst_count", step_count, 0);
        check("rst_busy", busy, 0);
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic run_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(SW2 ? clkdiv[24] : clkdiv[2]);
            adv();
            check(name, Clk_CPU, exp_q.pop_front());
        end
    endtask

    task automatic wait_low3(input logic [2:0] v);
        int k = 0;
        while (clkdiv[2:0] != v && k < 16) begin
            adv();
            k++;
        end
    endtask

    task automatic wait_clean(input logic lvl);
        int k = 0;
        while (btn_clean !== lvl && k < 400) begin
            adv();
            if (btn_clean !== lvl && lvl == 1'b0) check("rel_busy", busy, 1);
            k++;
        end
    endtask

    task automatic do_press(input logic [15:0] exp_count);
        int hi;
        wait_low3(3'd5);
        step_btn = 1'b1;
        ticks = 0;
        sc_q.push_back(exp_count);
        wait_clean(1'b1);
        check("deb_rise", btn_clean, 1);
        check("deb_ticks", ticks, 4);
        check("busy_pre", busy, 0);
        adv();
        check("pulse_start", Clk_CPU, 1);
        hi = 0;
        while (Clk_CPU === 1'b1 && hi < 300) begin
            check("busy_pulse", busy, 1);
            hi++;
            adv();
        end
        check("pulse_len", hi, PH);
        check("step_count", step_count, sc_q.pop_front());
        check("busy_wait", busy, 1);
        for (int i = 0; i < 40; i++) begin
            adv();
            check("held_no_pulse", Clk_CPU, 0);
        end
        check("held_busy", busy, 1);
        check("held_count", step_count, exp_count);
        step_btn = 1'b0;
        wait_clean(1'b0);
        check("deb_fall", btn_clean, 0);
        adv();
        check("busy_done", busy, 0);
    endtask

    initial begin
        int   k;
        int   hi;
        logic saw_hi;

        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_0007, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0008, 1'b0};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFC, 1'b1};
        vecs[5]  = '{1'b0, 32'h0100_0000, 1'b0};
        vecs[6]  = '{1'b1, 32'h0100_0000, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0004, 1'b0};
        vecs[8]  = '{1'b1, 32'h01FF_FFFF, 1'b1};
        vecs[9]  = '{1'b1, 32'h00FF_FFFF, 1'b0};
        vecs[10] = '{1'b0, 32'h00FF_FFFF, 1'b1};

        // Run, fast: Clk_CPU follows clkdiv[2] one cycle late.
        do_reset();
        clkdiv = 32'd0;
        count_en = 1'b1;
        run_check(40, "run_fast");
        check("run_busy", busy, 0);
        check("run_count", step_count, 0);

        // Run-mode vector table.
        count_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            SW2 = vecs[i].sw2;
            clkdiv = vecs[i].div;
            exp_q.push_back(vecs[i].exp_clk);
            adv();
            check("run_vec", Clk_CPU, exp_q.pop_front());
        end

        // Run, slow: across the bit-24 toggle.
        SW2 = 1'b1;
        clkdiv = 32'h00FF_FFF0;
        count_en = 1'b1;
        saw_hi = 1'b0;
        for (int i = 0; i < 40; i++) begin
            run_check(1, "run_slow");
            if (Clk_CPU === 1'b1) saw_hi = 1'b1;
        end
        check("run_slow_rose", saw_hi, 1);

        // Single step, twice.
        SW2 = 1'b0;
        step_mode = 1'b1;
        for (int i = 0; i < 16; i++) adv();
        check("step_idle_clk", Clk_CPU, 0);
        check("step_idle_busy", busy, 0);
        do_press(16'd1);
        do_press(16'd2);

        // Bounce rejection.
        do_reset();
        wait_low3(3'd5);
        for (int t = 0; t < 20; t++) begin
            step_btn = ~step_btn;
            for (int i = 0; i < 8; i++) begin
                adv();
                check("bounce_clean", btn_clean, 0);
                check("bounce_clk", Clk_CPU, 0);
            end
        end
        for (int i = 0; i < 40; i++) begin
            adv();
            check("bounce_settle", btn_clean, 0);
        end
        check("bounce_count", step_count, 0);

        // Mode switch during a run-mode high phase.
        step_mode = 1'b0;
        step_btn = 1'b0;
        do_reset();
        clkdiv = 32'd0;
        k = 0;
        while (Clk_CPU !== 1'b1 && k < 64) begin
            adv();
            k++;
        end
        check("mode_rise", Clk_CPU, 1);
        step_mode = 1'b1;
        hi = 1;
        adv();
        while (Clk_CPU === 1'b1 && hi < 64) begin
            hi++;
            adv();
        end
        check("mode_hi_len", hi, 4);
        check("mode_busy", busy, 0);
        for (int i = 0; i < 24; i++) begin
            adv();
            check("mode_idle_clk", Clk_CPU, 0);
        end

        // Asynchronous reset two cycles into a step pulse.
        wait_low3(3'd5);
        step_btn = 1'b1;
        wait_clean(1'b1);
        check("rp_clean", btn_clean, 1);
        adv();
        check("rp_pulse", Clk_CPU, 1);
        adv();
        check("rp_pulse2", Clk_CPU, 1);
        step_btn = 1'b0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            adv();
            check("rp_no_pulse", Clk_CPU, 0);
        end
        check("rp_count", step_count, 0);
        check("rp_busy", busy, 0);
        do_press(16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
